// File: rtl/sha3_pkg.sv
// Shared types and constants for the SHA-3 absorb front end.
package sha3_pkg;

    typedef logic [63:0] lane_t;

    // Rate in 64-bit lanes for the fixed-output SHA-3 variants.
    localparam int unsigned RATE_SHA3_224 = 18;
    localparam int unsigned RATE_SHA3_256 = 17;
    localparam int unsigned RATE_SHA3_384 = 13;
    localparam int unsigned RATE_SHA3_512 = 9;

    // First padding byte: SHA-3 hash vs. SHAKE XOF.
    localparam logic [7:0] DOMAIN_SHA3  = 8'h06;
    localparam logic [7:0] DOMAIN_SHAKE = 8'h1F;

    // Absorb FSM encoding.
    typedef logic [1:0] absorb_state_e;
    localparam absorb_state_e ST_COLLECT = 2'd0;
    localparam absorb_state_e ST_DRAIN   = 2'd1;
    localparam absorb_state_e ST_EMIT    = 2'd2;

endpackage

// File: rtl/sha3_lane_pad.sv
// Masks a message lane to its valid bytes and applies domain / final padding.
module sha3_lane_pad
    import sha3_pkg::*;
#(
    parameter logic [7:0] DOMAIN_BYTE = DOMAIN_SHA3
) (
    input  lane_t      lane,
    input  logic [3:0] nbytes,    // valid low bytes, 0..8
    input  logic       dom_flag,  // domain byte lands at byte nbytes of this lane
    input  logic       fin_flag,  // this lane holds the last rate byte
    output lane_t      padded
);

    // Keep valid bytes, then XOR padding; a coinciding domain and final byte merge to DOMAIN|0x80.
    always_comb begin
        padded = '0;
        for (int j = 0; j < 8; j++) begin
            if (j < int'(nbytes)) begin
                padded[8*j +: 8] = lane[8*j +: 8];
            end
            if (dom_flag && (j == int'(nbytes))) begin
                padded[8*j +: 8] = padded[8*j +: 8] ^ DOMAIN_BYTE;
            end
        end
        if (fin_flag) begin
            padded[63:56] = padded[63:56] ^ 8'h80;
        end
    end

endmodule

// File: rtl/sha3_absorb_packer.sv
// Packs a 64-bit little-endian byte stream into one padded Keccak state and
// strobes it out for a single-block SHA-3 permutation.
module sha3_absorb_packer
    import sha3_pkg::*;
#(
    parameter int unsigned RATE_LANES  = RATE_SHA3_256,
    parameter logic [7:0]  DOMAIN_BYTE = DOMAIN_SHA3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ivalid,
    output logic         iready,
    input  logic [63:0]  idata,
    input  logic         ilast,
    input  logic [3:0]   ibytes,
    output logic [319:0] osa,
    output logic [319:0] osb,
    output logic [319:0] osc,
    output logic [319:0] osd,
    output logic [319:0] ose,
    output logic         osample,
    output logic         oerror
);

    localparam logic [4:0] RATE_K    = 5'(RATE_LANES);
    localparam logic [4:0] FIN_K     = 5'(RATE_LANES - 1);
    localparam logic [8:0] LAST_BYTE = 9'(8 * RATE_LANES - 1);

    absorb_state_e state_q, state_d;
    logic [4:0]    k_q, k_d;
    lane_t         lanes_q [25];
    lane_t         lanes_d [25];
    logic          osample_q, osample_d;
    logic          oerror_q, oerror_d;

    logic       accept;
    logic [3:0] n_eff;
    logic [8:0] pos;
    logic       overflow;
    logic [4:0] k_nxt;
    lane_t      padded;

    assign iready = !rst && (state_q != ST_EMIT);
    assign accept = ivalid && iready;

    // Effective byte count: non-last beats are full, oversize counts saturate at 8.
    assign n_eff = (!ilast || (ibytes > 4'd8)) ? 4'd8 : ibytes;
    assign pos   = {1'b0, k_q, 3'b000} + {5'b0, n_eff};
    assign k_nxt = k_q + 5'd1;

    // Domain byte must fit at or below the final rate byte, and no beat may land past the rate.
    assign overflow = (k_q == RATE_K) || (ilast && (pos > LAST_BYTE));

    sha3_lane_pad #(
        .DOMAIN_BYTE (DOMAIN_BYTE)
    ) u_lane_pad (
        .lane     (idata),
        .nbytes   (n_eff),
        .dom_flag (ilast && (n_eff < 4'd8)),
        .fin_flag (ilast && (k_q == FIN_K)),
        .padded   (padded)
    );

    // Next-state: lane writes, padding, overflow recovery and post-emit clearing.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        lanes_d   = lanes_q;
        osample_d = 1'b0;
        oerror_d  = 1'b0;
        unique case (state_q)
            ST_COLLECT: begin
                if (accept) begin
                    if (overflow) begin
                        oerror_d = 1'b1;
                        for (int i = 0; i < 25; i++) lanes_d[i] = '0;
                        k_d     = '0;
                        state_d = ilast ? ST_COLLECT : ST_DRAIN;
                    end else begin
                        lanes_d[k_q] = padded;
                        k_d          = k_nxt;
                        if (ilast) begin
                            // Full last beat: domain byte opens the following lane.
                            if (n_eff == 4'd8) begin
                                lanes_d[k_nxt][7:0] = lanes_d[k_nxt][7:0] ^ DOMAIN_BYTE;
                            end
                            // Final rate byte not covered by the pad unit this cycle.
                            if (k_q != FIN_K) begin
                                lanes_d[FIN_K][63:56] = lanes_d[FIN_K][63:56] ^ 8'h80;
                            end
                            osample_d = 1'b1;
                            state_d   = ST_EMIT;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (accept && ilast) begin
                    for (int i = 0; i < 25; i++) lanes_d[i] = '0;
                    k_d     = '0;
                    state_d = ST_COLLECT;
                end
            end
            ST_EMIT: begin
                for (int i = 0; i < 25; i++) lanes_d[i] = '0;
                k_d     = '0;
                state_d = ST_COLLECT;
            end
            default: begin
                for (int i = 0; i < 25; i++) lanes_d[i] = '0;
                k_d     = '0;
                state_d = ST_COLLECT;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_COLLECT;
            k_q       <= '0;
            osample_q <= 1'b0;
            oerror_q  <= 1'b0;
            for (int i = 0; i < 25; i++) lanes_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            osample_q <= osample_d;
            oerror_q  <= oerror_d;
            for (int i = 0; i < 25; i++) lanes_q[i] <= lanes_d[i];
        end
    end

    assign osample = osample_q;
    assign oerror  = oerror_q;

    // Row y, element x = lane x+5y, element 0 in the low 64 bits.
    assign osa = {lanes_q[4],  lanes_q[3],  lanes_q[2],  lanes_q[1],  lanes_q[0]};
    assign osb = {lanes_q[9],  lanes_q[8],  lanes_q[7],  lanes_q[6],  lanes_q[5]};
    assign osc = {lanes_q[14], lanes_q[13], lanes_q[12], lanes_q[11], lanes_q[10]};
    assign osd = {lanes_q[19], lanes_q[18], lanes_q[17], lanes_q[16], lanes_q[15]};
    assign ose = {lanes_q[24], lanes_q[23], lanes_q[22], lanes_q[21], lanes_q[20]};

endmodule

// File: tb/tb_sha3_absorb_packer.sv
// Self-checking bench for sha3_absorb_packer (RATE 17, domain 0x06).
module tb_sha3_absorb_packer;

    localparam int         R   = 17;
    localparam logic [7:0] DOM = 8'h06;

    typedef struct packed {
        logic          err;
        logic [1599:0] st;
    } exp_t;

    typedef struct {
        int len;
        int seed;
        bit over;     // send ibytes>8 on a full last beat
        bit exp_err;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         ivalid;
    logic         iready;
    logic [63:0]  idata;
    logic         ilast;
    logic [3:0]   ibytes;
    logic [319:0] osa, osb, osc, osd, ose;
    logic         osample;
    logic         oerror;

    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            last_strobe_cyc = -1;
    int            iready_low = 0;
    logic [1599:0] cap;
    exp_t          sb [$];

    sha3_absorb_packer #(
        .RATE_LANES  (R),
        .DOMAIN_BYTE (DOM)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ivalid  (ivalid),
        .iready  (iready),
        .idata   (idata),
        .ilast   (ilast),
        .ibytes  (ibytes),
        .osa     (osa),
        .osb     (osb),
        .osc     (osc),
        .osd     (osd),
        .ose     (ose),
        .osample (osample),
        .oerror  (oerror)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] msg_byte(input int seed, input int i);
        if (seed == 0) return 8'(8'h61 + i);
        return 8'((seed * 37 + i * 11 + 3) & 255);
    endfunction

    function automatic exp_t model(input int len, input int seed, input bit err);
        exp_t e;
        e.err = err;
        e.st  = '0;
        if (!err) begin
            for (int i = 0; i < len; i++) e.st[8*i +: 8] = msg_byte(seed, i);
            e.st[8*len +: 8]         = e.st[8*len +: 8] ^ DOM;
            e.st[8*(8*R-1) +: 8]     = e.st[8*(8*R-1) +: 8] ^ 8'h80;
        end
        return e;
    endfunction

    // Drive one beat and hold it until accepted; acc is the accepting cycle.
    task automatic send_beat(input logic [63:0] d, input bit last, input logic [3:0] nb,
                             output int acc);
        int  t;
        bit  done;
        ivalid = 1'b1;
        idata  = d;
        ilast  = last;
        ibytes = nb;
        t      = 0;
        done   = 1'b0;
        acc    = -1;
        while (!done) begin
            @(negedge clk);
            if (iready) begin
                done = 1'b1;
                acc  = cyc;
            end
            @(posedge clk);
            #1;
            t++;
            if (!done && t > 50) begin
                n_cmp++;
                n_err++;
                $display("FAIL beat_accept_timeout: iready stayed 0 for %0d cycles, need 1", t);
                done = 1'b1;
            end
        end
    endtask

    task automatic send_msg(input int len, input int seed, input bit over, input bit push,
                            input bit exp_err, input bit hold, output int first);
        int beats;
        int acc;
        logic [63:0] d;
        beats = (len == 0) ? 1 : (len + 7) / 8;
        first = -1;
        for (int b = 0; b < beats; b++) begin
            for (int j = 0; j < 8; j++) d[8*j +: 8] = msg_byte(seed, 8*b + j);
            if (b == beats - 1) begin
                if (push) sb.push_back(model(len, seed, exp_err));
                send_beat(d, 1'b1, (over && (len - 8*b == 8)) ? 4'd12 : 4'(len - 8*b), acc);
            end else begin
                send_beat(d, 1'b0, 4'($urandom_range(0, 15)), acc);
            end
            if (b == 0) first = acc;
        end
        if (!hold) ivalid = 1'b0;
    endtask

    vec_t vec [12];
    int   first;
    logic [1599:0] tmp;

    initial begin
        exp_t e;
        vec[0]  = '{0,   0,  0, 0};
        vec[1]  = '{3,   0,  0, 0};
        vec[2]  = '{8,   5,  0, 0};
        vec[3]  = '{8,   6,  1, 0};
        vec[4]  = '{13,  7,  0, 0};
        vec[5]  = '{135, 9,  0, 0};
        vec[6]  = '{136, 10, 0, 1};
        vec[7]  = '{134, 11, 0, 0};
        vec[8]  = '{64,  12, 0, 0};
        vec[9]  = '{150, 13, 0, 1};
        vec[10] = '{1,   14, 1, 0};
        vec[11] = '{127, 15, 0, 0};

        rst    = 1'b1;
        ivalid = 1'b0;
        idata  = '0;
        ilast  = 1'b0;
        ibytes = '0;

        // Output monitor / scoreboard consumer.
        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (!iready) iready_low++;
                    if (osample && oerror) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL strobe_overlap: osample=1 oerror=1, need not both");
                    end
                    if (osample || oerror) begin
                        last_strobe_cyc = cyc;
                        cap = {ose, osd, osc, osb, osa};
                        n_cmp++;
                        if (sb.size() == 0) begin
                            n_err++;
                            $display("FAIL unexpected_strobe: osample=%0b oerror=%0b, need none",
                                     osample, oerror);
                        end else begin
                            e = sb.pop_front();
                            if (oerror !== e.err || osample !== !e.err) begin
                                n_err++;
                                $display("FAIL strobe_kind: osample=%0b oerror=%0b, need oerror=%0b",
                                         osample, oerror, e.err);
                            end else if (osample && cap !== e.st) begin
                                n_err++;
                                for (int l = 0; l < 25; l++) begin
                                    if (cap[64*l +: 64] !== e.st[64*l +: 64]) begin
                                        $display("FAIL state_lane%0d: got %h, need %h", l,
                                                 cap[64*l +: 64], e.st[64*l +: 64]);
                                        break;
                                    end
                                end
                            end
                        end
                    end
                end
            end
        join_none

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (iready !== 1'b0) begin n_err++; $display("FAIL rst_iready: got %b, need 0", iready); end
        n_cmp++; if (osample !== 1'b0) begin n_err++; $display("FAIL rst_osample: got %b, need 0", osample); end
        n_cmp++; if (oerror !== 1'b0) begin n_err++; $display("FAIL rst_oerror: got %b, need 0", oerror); end
        n_cmp++;
        if ({ose, osd, osc, osb, osa} !== '0) begin
            n_err++;
            $display("FAIL rst_rows: got nonzero (lane0=%h), need all 0", osa[63:0]);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (iready !== 1'b1) begin n_err++; $display("FAIL post_rst_iready: got %b, need 1", iready); end
        @(posedge clk);
        #1;

        // Table-driven messages, with latency check on accepted ones.
        for (int i = 0; i < 12; i++) begin
            send_msg(vec[i].len, vec[i].seed, vec[i].over, 1'b1, vec[i].exp_err, 1'b0, first);
            repeat (3) @(posedge clk);
            #1;
            if (!vec[i].exp_err) begin
                n_cmp++;
                if (last_strobe_cyc - first != ((vec[i].len == 0) ? 1 : (vec[i].len + 7) / 8)) begin
                    n_err++;
                    $display("FAIL latency_len%0d: got %0d cycles, need %0d", vec[i].len,
                             last_strobe_cyc - first,
                             (vec[i].len == 0) ? 1 : (vec[i].len + 7) / 8);
                end
            end
        end

        // Empty message against literal constants.
        send_msg(0, 1, 1'b0, 1'b1, 1'b0, 1'b0, first);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (cap[63:0] !== 64'h06) begin n_err++; $display("FAIL empty_lane0: got %h, need 0000000000000006", cap[63:0]); end
        n_cmp++; if (cap[16*64 +: 64] !== 64'h8000000000000000) begin n_err++; $display("FAIL empty_lane16: got %h, need 8000000000000000", cap[16*64 +: 64]); end
        tmp = cap;
        tmp[63:0] = '0;
        tmp[16*64 +: 64] = '0;
        n_cmp++; if (tmp !== '0) begin n_err++; $display("FAIL empty_other_lanes: got nonzero, need 0"); end

        // "abc" against literal constant.
        send_msg(3, 0, 1'b0, 1'b1, 1'b0, 1'b0, first);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (cap[63:0] !== 64'h0000000006636261) begin n_err++; $display("FAIL abc_lane0: got %h, need 0000000006636261", cap[63:0]); end

        // Back-to-back one-beat messages with ivalid held: iready low only in each EMIT.
        iready_low = 0;
        send_msg(5, 20, 1'b0, 1'b1, 1'b0, 1'b1, first);
        send_msg(7, 21, 1'b0, 1'b1, 1'b0, 1'b0, first);
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (iready_low != 2) begin n_err++; $display("FAIL b2b_iready_low: got %0d cycles, need 2", iready_low); end

        // Reset after 5 beats: no strobe, then a clean empty message.
        for (int b = 0; b < 5; b++) send_beat(64'hDEAD_BEEF_0000_0000 | 64'(b), 1'b0, 4'd8, first);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ivalid = 1'b0;
        rst    = 1'b0;
        send_msg(0, 1, 1'b0, 1'b1, 1'b0, 1'b0, first);
        repeat (3) @(posedge clk);
        #1;

        repeat (5) @(posedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL missing_strobes: got %0d outstanding, need 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
